// File: rtl/evt_gen_pkg.sv
// Shared state type and input-conditioning helpers for the periodic event generator.
package evt_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } evt_state_e;

    // A zero period would never expire, so it is treated as "every cycle".
    function automatic int clamp_period(input int period, input int max_period);
        if (period < 1) return 1;
        if (period > max_period) return max_period;
        return period;
    endfunction

    function automatic int clamp_count(input int count, input int max_count);
        return (count > max_count) ? max_count : count;
    endfunction

endpackage

// File: rtl/evt_generator_if.sv
// Control and status bundle of the event generator; the master drives start/stop/config.
interface evt_generator_if #(
    parameter int MAX_PERIOD = 1024,
    parameter int MAX_PULSES = 256
);
    localparam int PW = $clog2(MAX_PERIOD + 1);
    localparam int CW = $clog2(MAX_PULSES + 1);

    logic          start_in;
    logic          stop_in;
    logic [PW-1:0] period_in;
    logic [CW-1:0] count_in;
    logic          evt_out;
    logic          busy_out;
    logic          done_out;
    logic [CW-1:0] pulses_left_out;

    modport master (
        output start_in, stop_in, period_in, count_in,
        input  evt_out, busy_out, done_out, pulses_left_out
    );

    modport slave (
        input  start_in, stop_in, period_in, count_in,
        output evt_out, busy_out, done_out, pulses_left_out
    );
endinterface

// File: rtl/period_timer.sv
// Phase counter that runs 0..P-1 and flags the last phase; reloads P and clears on load_i.
module period_timer #(
    parameter int MAX_PERIOD = 1024,
    localparam int PW = $clog2(MAX_PERIOD + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          load_i,
    input  logic          en_i,
    input  logic [PW-1:0] period_i,
    output logic          expire_o
);
    logic [PW-1:0] period_q;
    logic [PW-1:0] phase_q;
    logic [PW-1:0] phase_d;

    assign expire_o = (phase_q == period_q - PW'(1));

    // Whenever the timer is not counting, the phase parks at zero.
    always_comb begin
        phase_d = '0;
        if (!load_i && en_i) begin
            phase_d = expire_o ? '0 : phase_q + PW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            period_q <= '0;
            phase_q  <= '0;
        end else begin
            phase_q <= phase_d;
            if (load_i) begin
                period_q <= period_i;
            end
        end
    end
endmodule

// File: rtl/evt_generator.sv
// Programmable periodic strobe source: FSM, pulse counter and registered outputs.
module evt_generator
    import evt_gen_pkg::*;
#(
    parameter int MAX_PERIOD = 1024,
    parameter int MAX_PULSES = 256
) (
    input  logic           clk_in,
    input  logic           rst_in,
    evt_generator_if.slave bus
);
    localparam int PW = $clog2(MAX_PERIOD + 1);
    localparam int CW = $clog2(MAX_PULSES + 1);

    evt_state_e    state_q, state_d;
    logic [CW-1:0] pulses_q, pulses_d;
    logic          finite_q, finite_d;
    logic          evt_q, evt_d;
    logic          load;
    logic          run_en;
    logic          expire;
    logic [PW-1:0] period_clamped;
    logic [CW-1:0] count_clamped;

    assign period_clamped = PW'(clamp_period(int'(bus.period_in), MAX_PERIOD));
    assign count_clamped  = CW'(clamp_count(int'(bus.count_in), MAX_PULSES));

    period_timer #(.MAX_PERIOD(MAX_PERIOD)) u_timer (
        .clk_i    (clk_in),
        .rst_i    (rst_in),
        .load_i   (load),
        .en_i     (run_en),
        .period_i (period_clamped),
        .expire_o (expire)
    );

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_d  = state_q;
        pulses_d = pulses_q;
        finite_d = finite_q;
        evt_d    = 1'b0;
        load     = 1'b0;
        run_en   = 1'b0;
        if (bus.stop_in && state_q == RUN) begin
            state_d  = IDLE;
            pulses_d = '0;
        end else if (bus.start_in) begin
            state_d  = RUN;
            load     = 1'b1;
            pulses_d = count_clamped;
            finite_d = (count_clamped != '0);
        end else begin
            unique case (state_q)
                RUN: begin
                    // The last strobe has already been shown; leave RUN one cycle later.
                    if (finite_q && pulses_q == '0) begin
                        state_d = DONE;
                    end else begin
                        run_en = 1'b1;
                        if (expire) begin
                            evt_d = 1'b1;
                            if (finite_q) pulses_d = pulses_q - CW'(1);
                        end
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q  <= IDLE;
            pulses_q <= '0;
            finite_q <= 1'b0;
            evt_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pulses_q <= pulses_d;
            finite_q <= finite_d;
            evt_q    <= evt_d;
        end
    end

    assign bus.evt_out         = evt_q;
    assign bus.busy_out        = (state_q == RUN);
    assign bus.done_out        = (state_q == DONE);
    assign bus.pulses_left_out = pulses_q;
endmodule

// File: tb/tb_evt_generator.sv
// Self-checking bench: directed vector table, corner-case sequences and random stimulus vs a schedule model.
module tb_evt_generator;
    localparam int MAX_PERIOD = 1024;
    localparam int MAX_PULSES = 256;
    localparam int PW = $clog2(MAX_PERIOD + 1);
    localparam int CW = $clog2(MAX_PULSES + 1);

    typedef struct {
        bit start;
        int period;
        int count;
        int evt;
        int busy;
        int done;
        int left;
    } vec_t;

    logic clk_in = 1'b0;
    logic rst_in;
    always #5 clk_in = ~clk_in;

    evt_generator_if #(.MAX_PERIOD(MAX_PERIOD), .MAX_PULSES(MAX_PULSES)) bus ();

    evt_generator #(.MAX_PERIOD(MAX_PERIOD), .MAX_PULSES(MAX_PULSES)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    int total = 0;
    int bad   = 0;
    int ecount = 0;

    // Reference model: a run is a start edge, a period and a pulse count; outputs follow by arithmetic.
    bit m_run  = 1'b0;
    bit m_busy = 1'b0;
    int m_s = 0;
    int m_p = 1;
    int m_n = 0;

    vec_t tbl[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s edge=%0d: got %0d expected %0d", name, ecount, act, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_evt"},  bus.evt_out, 0);
        check({tag, "_busy"}, bus.busy_out, 0);
        check({tag, "_done"}, bus.done_out, 0);
        check({tag, "_left"}, bus.pulses_left_out, 0);
    endtask

    task automatic drive(input bit st, input bit sp, input int p, input int n);
        bus.start_in  = st;
        bus.stop_in   = sp;
        bus.period_in = PW'(p);
        bus.count_in  = CW'(n);
    endtask

    task automatic model_out(output int evt, output int busy, output int done, output int left);
        int d;
        int last;
        evt = 0; busy = 0; done = 0; left = 0;
        if (m_run) begin
            d = ecount - m_s;
            if (m_n == 0) begin
                busy = 1;
                evt  = (d > 0 && d % m_p == 0) ? 1 : 0;
            end else begin
                last = m_n * m_p;
                busy = (d <= last) ? 1 : 0;
                evt  = (d > 0 && d % m_p == 0 && d <= last) ? 1 : 0;
                done = (d == last + 1) ? 1 : 0;
                left = (busy != 0) ? m_n - d / m_p : 0;
            end
        end
    endtask

    // One clock: update the model with the inputs sampled at the edge, then compare at the falling edge.
    task automatic cyc();
        int x_evt, x_busy, x_done, x_left;
        @(posedge clk_in);
        ecount++;
        if (bus.stop_in && m_busy) begin
            m_run = 1'b0;
        end else if (bus.start_in) begin
            m_run = 1'b1;
            m_s   = ecount;
            m_p   = (bus.period_in == 0) ? 1 :
                    (int'(bus.period_in) > MAX_PERIOD) ? MAX_PERIOD : int'(bus.period_in);
            m_n   = (int'(bus.count_in) > MAX_PULSES) ? MAX_PULSES : int'(bus.count_in);
        end
        @(negedge clk_in);
        model_out(x_evt, x_busy, x_done, x_left);
        check("m_evt",  bus.evt_out, x_evt);
        check("m_busy", bus.busy_out, x_busy);
        check("m_done", bus.done_out, x_done);
        check("m_left", bus.pulses_left_out, x_left);
        m_busy = (x_busy != 0);
    endtask

    initial begin
        // period=3, count=4 started at relative edge 0; later config inputs must be ignored.
        tbl[0]  = '{1, 3, 4, 0, 1, 0, 4};
        tbl[1]  = '{0, 7, 9, 0, 1, 0, 4};
        tbl[2]  = '{0, 7, 9, 0, 1, 0, 4};
        tbl[3]  = '{0, 7, 9, 1, 1, 0, 3};
        tbl[4]  = '{0, 7, 9, 0, 1, 0, 3};
        tbl[5]  = '{0, 7, 9, 0, 1, 0, 3};
        tbl[6]  = '{0, 7, 9, 1, 1, 0, 2};
        tbl[7]  = '{0, 7, 9, 0, 1, 0, 2};
        tbl[8]  = '{0, 7, 9, 0, 1, 0, 2};
        tbl[9]  = '{0, 7, 9, 1, 1, 0, 1};
        tbl[10] = '{0, 7, 9, 0, 1, 0, 1};
        tbl[11] = '{0, 7, 9, 0, 1, 0, 1};
        tbl[12] = '{0, 7, 9, 1, 1, 0, 0};
        tbl[13] = '{0, 7, 9, 0, 0, 1, 0};
        tbl[14] = '{0, 7, 9, 0, 0, 0, 0};

        rst_in = 1'b1;
        drive(0, 0, 0, 0);
        #12;
        check_idle("rst");
        @(negedge clk_in);
        rst_in = 1'b0;

        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].start, 0, tbl[i].period, tbl[i].count);
            cyc();
            check("tbl_evt",  bus.evt_out, tbl[i].evt);
            check("tbl_busy", bus.busy_out, tbl[i].busy);
            check("tbl_done", bus.done_out, tbl[i].done);
            check("tbl_left", bus.pulses_left_out, tbl[i].left);
        end

        // Period 1, infinite, stopped at relative edge 20.
        drive(1, 0, 1, 0);
        cyc();
        drive(0, 0, 0, 0);
        cyc();
        check("p1_evt", bus.evt_out, 1);
        repeat (18) cyc();
        drive(0, 1, 0, 0);
        cyc();
        check("p1_stop_evt",  bus.evt_out, 0);
        check("p1_stop_busy", bus.busy_out, 0);
        drive(0, 0, 0, 0);
        cyc();
        check("p1_nodone", bus.done_out, 0);

        // Period 0 behaves as period 1.
        drive(1, 0, 0, 3);
        cyc();
        drive(0, 0, 0, 0);
        cyc();
        check("p0_evt", bus.evt_out, 1);
        repeat (4) cyc();

        // Oversized period clamps to MAX_PERIOD.
        drive(1, 0, MAX_PERIOD + 5, 2);
        cyc();
        drive(0, 0, 0, 0);
        repeat (MAX_PERIOD - 1) cyc();
        check("pmax_early", bus.evt_out, 0);
        cyc();
        check("pmax_evt1", bus.evt_out, 1);
        repeat (MAX_PERIOD) cyc();
        check("pmax_evt2", bus.evt_out, 1);
        check("pmax_left", bus.pulses_left_out, 0);
        cyc();
        check("pmax_done", bus.done_out, 1);
        cyc();

        // Restart mid-run with a new period and count.
        drive(1, 0, 5, 3);
        cyc();
        drive(0, 0, 0, 0);
        repeat (6) cyc();
        drive(1, 0, 2, 3);
        cyc();
        check("rs_left", bus.pulses_left_out, 3);
        drive(0, 0, 0, 0);
        cyc();
        check("rs_gap", bus.evt_out, 0);
        cyc();
        check("rs_evt",  bus.evt_out, 1);
        check("rs_left2", bus.pulses_left_out, 2);
        repeat (6) cyc();

        // Stop on the edge that would fire the final strobe.
        drive(1, 0, 4, 2);
        cyc();
        drive(0, 0, 0, 0);
        repeat (7) cyc();
        drive(0, 1, 0, 0);
        cyc();
        check_idle("stop_strobe");
        drive(0, 0, 0, 0);
        cyc();
        check("stop_nodone", bus.done_out, 0);

        // Asynchronous reset between edges during a run, then a clean restart.
        drive(1, 0, 3, 0);
        cyc();
        drive(0, 0, 0, 0);
        repeat (4) cyc();
        #2 rst_in = 1'b1;
        #1 check_idle("arst");
        m_run  = 1'b0;
        m_busy = 1'b0;
        #1 rst_in = 1'b0;
        drive(1, 0, 2, 2);
        cyc();
        drive(0, 0, 0, 0);
        cyc();
        cyc();
        check("arst_evt", bus.evt_out, 1);
        repeat (4) cyc();

        // Random traffic against the model.
        repeat (3000) begin
            drive($urandom_range(0, 39) == 0, $urandom_range(0, 59) == 0,
                  $urandom_range(0, 12),
                  ($urandom_range(0, 7) == 0) ? $urandom_range(0, 511) : $urandom_range(0, 5));
            cyc();
        end
        drive(0, 1, 0, 0);
        cyc();
        drive(0, 0, 0, 0);
        repeat (3) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
